// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset sequencer: stretch, PLL-lock qualify, ordered per-domain release
// Software-requested resets are acknowledged with a one-cycle pulse when the sequence completes.
module rst_seq #(
    parameter int NUM_STAGES = 4,
    parameter int STRETCH    = 16,
    parameter int STAGE_GAP  = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  rst_done,
    output logic                  sw_rst_ack
);

    localparam int CNT_MAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH);
    localparam logic [CW-1:0] GAP_END     = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_STAGES - 1);

    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_inc;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  rst_done_q, rst_done_d;
    logic                  sw_rst_ack_q, sw_rst_ack_d;
    logic                  sw_pend_q, sw_pend_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stage_rst_d  = stage_rst_q;
        sw_pend_d    = sw_pend_q;
        cnt_inc      = cnt_q + CW'(1);
        rst_done_d   = 1'b0;
        sw_rst_ack_d = 1'b0;

        case (state_q)
            ST_HOLD: begin
                stage_rst_d = '1;
                if (cnt_inc == STRETCH_END) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                stage_rst_d = '1;
                if (pll_locked) begin
                    stage_rst_d[0] = 1'b0;
                    cnt_d          = '0;
                    idx_d          = IW'(1);
                    state_d        = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!pll_locked) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                end else if (cnt_q == GAP_END) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == i[IW-1:0]) begin
                            stage_rst_d[i] = 1'b0;
                        end
                    end
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                stage_rst_d = '0;
                // Lock loss wins over a coincident software request, which is then dropped.
                if (!pll_locked || sw_rst_req) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    if (pll_locked) begin
                        sw_pend_d = 1'b1;
                    end
                end
            end
        endcase

        rst_done_d = (state_d == ST_RUN);
        if ((state_d == ST_RUN) && (state_q != ST_RUN) && sw_pend_q) begin
            sw_rst_ack_d = 1'b1;
            sw_pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_rst_q  <= '1;
            rst_done_q   <= 1'b0;
            sw_rst_ack_q <= 1'b0;
            sw_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_rst_q  <= stage_rst_d;
            rst_done_q   <= rst_done_d;
            sw_rst_ack_q <= sw_rst_ack_d;
            sw_pend_q    <= sw_pend_d;
        end
    end

    assign stage_rst  = stage_rst_q;
    assign rst_done   = rst_done_q;
    assign sw_rst_ack = sw_rst_ack_q;

endmodule
